// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package pwm_pkg;

  // Default width of a duty/counter field.
  localparam int DUTY_W_DEF = 4;

  // Duty field at the default width.
  typedef logic [DUTY_W_DEF-1:0] duty_t;

  // Request priority encoding: preset beats everything, then a simultaneous
  // inc/dec edge pair cancels out, then inc, then dec.
  localparam logic [1:0] REQ_HOLD   = 2'd0;
  localparam logic [1:0] REQ_PRESET = 2'd1;
  localparam logic [1:0] REQ_INC    = 2'd2;
  localparam logic [1:0] REQ_DEC    = 2'd3;

  // Ceiling log2, at least 1 so that it can size a register directly.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Collapse the three per-channel request sources into one action.
  function automatic logic [1:0] req_decode(input logic preset_i,
                                            input logic inc_edge,
                                            input logic dec_edge);
    if (preset_i)                   return REQ_PRESET;
    else if (inc_edge && dec_edge)  return REQ_HOLD;
    else if (inc_edge)              return REQ_INC;
    else if (dec_edge)              return REQ_DEC;
    else                            return REQ_HOLD;
  endfunction

  // Parameter consistency: the counter must hold PERIOD-1 and any duty up to
  // PERIOD, the reset duty must lie in 0..PERIOD, and dead time is >= 1.
  function automatic bit cfg_ok(input int cnt_w, input int period,
                                input int duty_init, input int dead);
    return (cnt_w >= 1) && (cnt_w < 31) && (period >= 1) &&
           (period <= (1 << cnt_w) - 1) &&
           (duty_init >= 0) && (duty_init <= period) && (dead >= 1);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: request edge detect, pending/active duty, compare, optional dead time (PWM_DEADTIME_EN).
// Latency: requests update the pending duty next cycle; pwm is registered one cycle after the shared counter.
// Backpressure: none; requests are accepted every cycle, duty saturates at 0 and PERIOD.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int PERIOD    = 10,
  parameter int DUTY_INIT = 5,
`ifdef PWM_DEADTIME_EN
  parameter int DEAD      = 1,
`endif
  parameter int STEP      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_preset,
  output logic             o_pwm,
`ifdef PWM_DEADTIME_EN
  output logic             o_pwm_n,
`endif
  output logic [CNT_W-1:0] o_duty
);

  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DUTY_INIT);
  localparam logic [CNT_W:0]   PERIOD_X = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]   STEP_X   = (CNT_W+1)'(STEP);

  logic             r_inc_d;
  logic             r_dec_d;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] w_duty_nxt;
  logic [CNT_W:0]   w_duty_x;
  logic [CNT_W:0]   w_up;
  logic [CNT_W:0]   w_up_sat;
  logic [CNT_W:0]   w_dn_sat;
  logic             w_inc_edge;
  logic             w_dec_edge;
  logic [1:0]       w_req;
  logic             w_raw;

  assign w_inc_edge = i_inc & ~r_inc_d;
  assign w_dec_edge = i_dec & ~r_dec_d;
  assign w_req      = req_decode(i_preset, w_inc_edge, w_dec_edge);

  // One bit of headroom so the saturation compares never see a wrapped value.
  assign w_duty_x = {1'b0, r_duty};
  assign w_up     = w_duty_x + STEP_X;
  assign w_up_sat = (w_up > PERIOD_X) ? PERIOD_X : w_up;
  assign w_dn_sat = (w_duty_x >= STEP_X) ? (w_duty_x - STEP_X) : '0;

  // Next pending duty from the decoded request.
  always_comb begin
    w_duty_nxt = r_duty;
    case (w_req)
      REQ_PRESET: w_duty_nxt = DUTY_RST;
      REQ_INC:    w_duty_nxt = CNT_W'(w_up_sat);
      REQ_DEC:    w_duty_nxt = CNT_W'(w_dn_sat);
      default:    w_duty_nxt = r_duty;
    endcase
  end

  // Request history and pending duty; runs whether or not the counter is enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_inc_d <= 1'b0;
      r_dec_d <= 1'b0;
      r_duty  <= DUTY_RST;
    end else begin
      r_inc_d <= i_inc;
      r_dec_d <= i_dec;
      r_duty  <= w_duty_nxt;
    end
  end

  // Shadow copy taken on the last count of a period so a period never changes duty mid-way.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_active <= DUTY_RST;
    end else if (i_load) begin
      r_active <= r_duty;
    end
  end

  assign w_raw  = i_run & (i_cnt < r_active);
  assign o_duty = r_duty;

`ifdef PWM_DEADTIME_EN
  localparam int DT_W = clog2(DEAD + 1);
  localparam logic [DT_W-1:0] DEAD_C = DT_W'(DEAD);

  logic            w_raw_n;
  logic [DT_W-1:0] r_hi_run;
  logic [DT_W-1:0] r_lo_run;
  logic            r_pwm;
  logic            r_pwm_n;

  assign w_raw_n = i_run & ~(i_cnt < r_active);

  // Count consecutive cycles of each polarity; an output rises only once its
  // polarity has already been held DEAD cycles, which swallows short pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi_run <= '0;
      r_lo_run <= '0;
      r_pwm    <= 1'b0;
      r_pwm_n  <= 1'b0;
    end else begin
      r_hi_run <= !w_raw   ? '0 : (r_hi_run == DEAD_C) ? r_hi_run : r_hi_run + DT_W'(1);
      r_lo_run <= !w_raw_n ? '0 : (r_lo_run == DEAD_C) ? r_lo_run : r_lo_run + DT_W'(1);
      r_pwm    <= w_raw   & (r_hi_run >= DEAD_C);
      r_pwm_n  <= w_raw_n & (r_lo_run >= DEAD_C);
    end
  end

  assign o_pwm   = r_pwm;
  assign o_pwm_n = r_pwm_n;
`else
  logic r_pwm;

  // Registered compare output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_raw;
    end
  end

  assign o_pwm = r_pwm;
`endif

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM with a shared period counter; optional complementary dead-time outputs under PWM_DEADTIME_EN.
// Latency: pwm and period_start are registered one cycle after the counter; duty changes apply at the next period.
// Backpressure: none; en=0 freezes the counter and forces outputs low while requests are still accepted.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = DUTY_W_DEF,
  parameter int PERIOD    = 10,
  parameter int DUTY_INIT = 5,
  parameter int STEP      = 1,
  parameter int DEAD      = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic [CHANNELS-1:0]       preset,
  output logic [CHANNELS-1:0]       pwm,
`ifdef PWM_DEADTIME_EN
  output logic [CHANNELS-1:0]       pwm_n,
`endif
  output logic [CHANNELS*CNT_W-1:0] duty,
  output logic                      period_start
);

  if (!cfg_ok(CNT_W, PERIOD, DUTY_INIT, DEAD)) begin : g_cfg_bad
    $error("pwm_multi_channel: inconsistent CNT_W/PERIOD/DUTY_INIT/DEAD");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_period_start;
  logic             w_load;

  // Shared period counter and the period-start marker, both frozen while en=0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= en & (r_cnt == '0);
      if (en) begin
        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_load       = en & (r_cnt == LAST);
  assign period_start = r_period_start;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel #(
      .CNT_W     (CNT_W),
      .PERIOD    (PERIOD),
      .DUTY_INIT (DUTY_INIT),
`ifdef PWM_DEADTIME_EN
      .DEAD      (DEAD),
`endif
      .STEP      (STEP)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_run    (en),
      .i_load   (w_load),
      .i_cnt    (r_cnt),
      .i_inc    (inc[g]),
      .i_dec    (dec[g]),
      .i_preset (preset[g]),
      .o_pwm    (pwm[g]),
`ifdef PWM_DEADTIME_EN
      .o_pwm_n  (pwm_n[g]),
`endif
      .o_duty   (duty[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: directed scenarios plus random traffic against a behavioural model.
module tb_pwm_multi_channel;

  localparam int NCH   = 4;
  localparam int W     = 4;
  localparam int PER   = 10;
  localparam int DINIT = 5;
  localparam int STEP  = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [NCH-1:0]    inc;
  logic [NCH-1:0]    dec;
  logic [NCH-1:0]    preset;
  logic [NCH-1:0]    pwm;
  logic [NCH*W-1:0]  duty;
  logic              period_start;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  int m_cnt;
  int m_duty [NCH];
  int m_act  [NCH];
  bit m_pwm  [NCH];
  bit m_ps;
  bit m_inc_d [NCH];
  bit m_dec_d [NCH];

  pwm_multi_channel #(
    .CHANNELS(NCH), .CNT_W(W), .PERIOD(PER), .DUTY_INIT(DINIT), .STEP(STEP), .DEAD(1)
  ) dut (
    .clk(clk), .reset(rst_n), .en(en), .inc(inc), .dec(dec), .preset(preset),
    .pwm(pwm), .duty(duty), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: applies the behavioural rules once per rising edge.
  always @(posedge clk) begin
    bit ie;
    bit de;
    if (!rst_n) begin
      m_cnt = 0;
      m_ps  = 0;
      for (int i = 0; i < NCH; i++) begin
        m_duty[i] = DINIT; m_act[i] = DINIT; m_pwm[i] = 0;
        m_inc_d[i] = 0; m_dec_d[i] = 0;
      end
    end else begin
      m_ps = en && (m_cnt == 0);
      for (int i = 0; i < NCH; i++) begin
        m_pwm[i] = en && (m_cnt < m_act[i]);
        if (en && m_cnt == PER - 1) m_act[i] = m_duty[i];
        ie = inc[i] && !m_inc_d[i];
        de = dec[i] && !m_dec_d[i];
        if (preset[i])        m_duty[i] = DINIT;
        else if (ie && de)    m_duty[i] = m_duty[i];
        else if (ie)          m_duty[i] = (m_duty[i] + STEP > PER) ? PER : m_duty[i] + STEP;
        else if (de)          m_duty[i] = (m_duty[i] - STEP < 0) ? 0 : m_duty[i] - STEP;
        m_inc_d[i] = inc[i];
        m_dec_d[i] = dec[i];
      end
      if (en) m_cnt = (m_cnt + 1) % PER;
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic [NCH-1:0]   ep;
    logic [NCH*W-1:0] ed;
    if (chk_en) begin
      for (int i = 0; i < NCH; i++) begin
        ep[i]         = m_pwm[i];
        ed[i*W +: W]  = W'(m_duty[i]);
      end
      check("cyc_pwm", int'(pwm), int'(ep));
      check("cyc_duty", int'(duty), int'(ed));
      check("cyc_period_start", int'(period_start), int'(m_ps));
    end
  end

  function automatic int duty_of(input int ch);
    logic [NCH*W-1:0] d;
    d = duty;
    return int'(d[ch*W +: W]);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int ch, input bit up);
    if (up) inc[ch] = 1'b1; else dec[ch] = 1'b1;
    tick(1);
    inc[ch] = 1'b0; dec[ch] = 1'b0;
    tick(1);
  endtask

  initial begin
    int hi [NCH];
    int ps_n;
    int hc;
    bit found;
    logic [NCH-1:0] r4;

    rst_n = 1'b0; en = 1'b0; inc = '0; dec = '0; preset = '0;
    tick(3);
    chk_en = 1'b1;
    for (int i = 0; i < NCH; i++) check($sformatf("reset_duty_ch%0d", i), duty_of(i), DINIT);
    check("reset_pwm", int'(pwm), 0);
    check("reset_period_start", int'(period_start), 0);

    // defaults: 5 of 10 high, one period_start per 10 cycles
    rst_n = 1'b1; en = 1'b1;
    tick(10);
    ps_n = 0;
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      ps_n += int'(period_start);
      for (int i = 0; i < NCH; i++) hi[i] += int'(pwm[i]);
    end
    check("default_period_starts", ps_n, 3);
    for (int i = 0; i < NCH; i++) check($sformatf("default_high_ch%0d", i), hi[i], 15);

    // held inc is a single step
    inc[0] = 1'b1;
    tick(20);
    inc[0] = 1'b0;
    tick(1);
    check("held_inc_duty0", duty_of(0), 6);
    check("held_inc_duty1", duty_of(1), 5);

    // saturate high, then low, on channel 1
    for (int k = 0; k < 7; k++) pulse(1, 1'b1);
    check("sat_high_duty1", duty_of(1), PER);
    tick(20);
    hc = 0;
    for (int c = 0; c < 10; c++) begin tick(1); hc += int'(pwm[1]); end
    check("sat_high_pwm1", hc, 10);
    for (int k = 0; k < 11; k++) pulse(1, 1'b0);
    check("sat_low_duty1", duty_of(1), 0);
    tick(20);
    hc = 0;
    for (int c = 0; c < 10; c++) begin tick(1); hc += int'(pwm[1]); end
    check("sat_low_pwm1", hc, 0);

    // simultaneous edges
    inc[2] = 1'b1; dec[2] = 1'b1;
    tick(1);
    inc[2] = 1'b0; dec[2] = 1'b0;
    tick(1);
    check("inc_dec_same_cycle_duty2", duty_of(2), 5);
    pulse(3, 1'b1);
    check("pre_preset_duty3", duty_of(3), 6);
    preset[3] = 1'b1; inc[3] = 1'b1;
    tick(1);
    preset[3] = 1'b0; inc[3] = 1'b0;
    tick(1);
    check("preset_beats_inc_duty3", duty_of(3), 5);

    // en low forces outputs low
    en = 1'b0;
    tick(3);
    check("en_low_pwm", int'(pwm), 0);
    en = 1'b1;

    // mid-period reset at cnt=7 with duty 8 on channel 0
    pulse(0, 1'b1); pulse(0, 1'b1);
    check("ch0_duty8", duty_of(0), 8);
    tick(12);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (m_cnt == 7) found = 1'b1; else tick(1);
    end
    check("found_cnt7", int'(found), 1);
    rst_n = 1'b0;
    tick(1);
    check("midreset_pwm", int'(pwm), 0);
    check("midreset_duty0", duty_of(0), DINIT);
    rst_n = 1'b1;
    tick(1);
    check("after_reset_period_start", int'(period_start), 1);
    check("after_reset_pwm", int'(pwm), 4'hF);
    hc = 0;
    for (int c = 0; c < 9; c++) begin tick(1); hc += int'(pwm[0]); end
    check("after_reset_pwm0_high", hc, 4);

    // random traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      r4    = NCH'($urandom);
      inc   = ($urandom_range(0, 2) == 0) ? r4 : inc;
      r4    = NCH'($urandom);
      dec   = ($urandom_range(0, 2) == 0) ? r4 : dec;
      r4    = NCH'($urandom);
      preset = ($urandom_range(0, 24) == 0) ? r4 : '0;
      rst_n = ($urandom_range(0, 399) != 0);
      tick(1);
    end
    rst_n = 1'b1; inc = '0; dec = '0; preset = '0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
